// File: rtl/wb_cmd_master_if.sv
// Bundle of the command/response streams and the Wishbone classic bus seen by wb_cmd_master.
// The master modport is the initiator's view; the slave modport is the view of whatever drives it.
interface wb_cmd_master_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    // command stream
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_sel;

    // response stream
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;

    // Wishbone classic bus
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [SW-1:0] o_wb_sel;
    logic          i_wb_ack;
    logic [DW-1:0] i_wb_data;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err,
        input  i_rsp_ready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err,
        output i_rsp_ready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out, one response back.
// A stalled slave is reported as an error response after TIMEOUT cycles (TIMEOUT = 0 waits forever).
module wb_cmd_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            rst,
    wb_cmd_master_if.master bus
);
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic        TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    // State and all outputs are registered; reset also abandons any cycle in flight.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid && cmd_ready_q) begin
                    we_d        = bus.i_cmd_we;
                    addr_d      = bus.i_cmd_addr;
                    data_d      = bus.i_cmd_data;
                    sel_d       = bus.i_cmd_sel;
                    cyc_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end
            end

            BUS: begin
                cnt_d = cnt_q + CW'(1);
                // An ack on the expiry edge still counts as a successful transfer.
                if (bus.i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = we_q ? '0 : bus.i_wb_data;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end

            RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    assign bus.o_cmd_ready = cmd_ready_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = cyc_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_addr   = addr_q;
    assign bus.o_wb_data   = data_q;
    assign bus.o_wb_sel    = sel_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: commands push expected bus cycles and responses;
// a Wishbone slave model and a response monitor pop and compare independently.
module tb_wb_cmd_master;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        int unsigned   wait_n;   // slave wait states before ack
        logic [DW-1:0] rdata;
    } xfer_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .rst   (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    xfer_t wb_q[$];
    rsp_t  rsp_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  outstanding = 1'b0;
    logic  bp_hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: a slave acking after w wait states beats the timeout iff w < TIMEOUT.
    function automatic rsp_t model_rsp(input xfer_t x);
        rsp_t r;
        if (x.wait_n < TIMEOUT) begin
            r.err  = 1'b0;
            r.data = x.we ? '0 : x.rdata;
        end else begin
            r.err  = 1'b1;
            r.data = '0;
        end
        return r;
    endfunction

    function automatic int unsigned model_cyc_len(input xfer_t x);
        return (x.wait_n < TIMEOUT) ? x.wait_n + 1 : TIMEOUT;
    endfunction

    function automatic xfer_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [SW-1:0] sel, input int unsigned w, input logic [DW-1:0] rdata);
        xfer_t x;
        x.we = we; x.addr = addr; x.data = data; x.sel = sel; x.wait_n = w; x.rdata = rdata;
        return x;
    endfunction

    task automatic send(input xfer_t x);
        int n = 0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = x.we;
        bus.i_cmd_addr  = x.addr;
        bus.i_cmd_data  = x.data;
        bus.i_cmd_sel   = x.sel;
        while (!bus.o_cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            fail_timeout("cmd_accept");
            bus.i_cmd_valid = 1'b0;
            return;
        end
        wb_q.push_back(x);
        rsp_q.push_back(model_rsp(x));
        @(posedge clk);
        outstanding = 1'b1;
        #1 bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || outstanding) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_timeout("wait_idle");
    endtask

    // Wishbone slave model: checks each cycle's fields and length, acks per plan, drives stray acks when idle.
    initial begin
        xfer_t       cur;
        int unsigned cnt;
        int unsigned len;
        logic        busy;
        busy = 1'b0; cnt = 0; len = 0;
        bus.i_wb_ack  = 1'b0;
        bus.i_wb_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                bus.i_wb_ack = 1'b0;
                continue;
            end
            if (bus.o_wb_cyc && !busy) begin
                if (wb_q.size() == 0) begin
                    check("spurious_cyc", 64'(bus.o_wb_cyc), 64'(0));
                    continue;
                end
                cur  = wb_q.pop_front();
                busy = 1'b1;
                cnt  = 0;
                len  = 0;
            end
            if (busy && bus.o_wb_cyc) begin
                check("wb_stb", 64'(bus.o_wb_stb), 64'(1));
                check("wb_we", 64'(bus.o_wb_we), 64'(cur.we));
                check("wb_addr", 64'(bus.o_wb_addr), 64'(cur.addr));
                check("wb_data", 64'(bus.o_wb_data), 64'(cur.data));
                check("wb_sel", 64'(bus.o_wb_sel), 64'(cur.sel));
                len++;
                bus.i_wb_ack  = (cnt == cur.wait_n);
                bus.i_wb_data = (cnt == cur.wait_n) ? cur.rdata : DW'($urandom());
                cnt++;
            end else begin
                check("wb_stb_low", 64'(bus.o_wb_stb), 64'(0));
                if (busy) begin
                    check("cyc_len", 64'(len), 64'(model_cyc_len(cur)));
                    check("rsp_valid_at_cyc_drop", 64'(bus.o_rsp_valid), 64'(1));
                    busy = 1'b0;
                end
                bus.i_wb_ack  = ($urandom_range(0, 3) == 0);
                bus.i_wb_data = DW'($urandom());
            end
        end
    end

    // Response monitor and rsp_ready driver: compares every presented response against the scoreboard.
    initial begin
        bus.i_rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (rst) continue;
            check("cmd_ready", 64'(bus.o_cmd_ready), 64'(!outstanding));
            if (bus.o_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.o_rsp_valid), 64'(0));
                end else begin
                    check("rsp_data", 64'(bus.o_rsp_data), 64'(rsp_q[0].data));
                    check("rsp_err", 64'(bus.o_rsp_err), 64'(rsp_q[0].err));
                    if (bus.i_rsp_ready) begin
                        void'(rsp_q.pop_front());
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_we    = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_data  = '0;
        bus.i_cmd_sel   = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'(1));
        check("rst_cyc", 64'(bus.o_wb_cyc), 64'(0));
        check("rst_stb", 64'(bus.o_wb_stb), 64'(0));
        check("rst_we", 64'(bus.o_wb_we), 64'(0));
        check("rst_addr", 64'(bus.o_wb_addr), 64'(0));
        check("rst_wdata", 64'(bus.o_wb_data), 64'(0));
        check("rst_sel", 64'(bus.o_wb_sel), 64'(0));
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(bus.o_rsp_data), 64'(0));
        check("rst_rsp_err", 64'(bus.o_rsp_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle write, waited read, and a slave that never acks.
        send(mk(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 32'hDEAD_BEEF));
        send(mk(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'h00AB_CDEF));
        send(mk(1'b0, 32'h3000_0008, 32'h0, 4'hF, 20, 32'h5555_AAAA));
        wait_idle();

        // Ack exactly on the timeout edge, and one cycle too late.
        send(mk(1'b0, 32'h3000_000C, 32'h0, 4'h3, TIMEOUT - 1, 32'hCAFE_F00D));
        send(mk(1'b0, 32'h3000_0010, 32'h0, 4'hC, TIMEOUT, 32'hBAAD_F00D));
        wait_idle();

        // Response held back for a while; the next command waits for the handshake.
        bp_hold = 1'b1;
        send(mk(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 32'h0BAD_CAFE));
        fork
            begin
                repeat (12) @(negedge clk);
                bp_hold = 1'b0;
            end
            send(mk(1'b1, 32'h3000_0018, 32'hA5A5_5A5A, 4'h5, 2, 32'h0));
        join
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            send(mk(1'($urandom()), AW'($urandom()), DW'($urandom()), SW'($urandom()),
                    $urandom_range(0, 10), DW'($urandom())));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset while a cycle is in flight drops cyc/stb at once and yields no response.
        send(mk(1'b0, 32'h3000_0020, 32'h0, 4'hF, 30, 32'h1111_2222));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        outstanding = 1'b0;
        #1;
        check("async_rst_cyc", 64'(bus.o_wb_cyc), 64'(0));
        check("async_rst_stb", 64'(bus.o_wb_stb), 64'(0));
        check("async_rst_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
        check("async_rst_cmd_ready", 64'(bus.o_cmd_ready), 64'(1));
        wb_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_cmd_ready", 64'(bus.o_cmd_ready), 64'(1));
        check("post_rst_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
        check("post_rst_cyc", 64'(bus.o_wb_cyc), 64'(0));

        send(mk(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h7777_8888));
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
